// File: rtl/serial_alu_seq.sv
// 2-bit digit-serial ALU and sequencer for the RV32E core (LSB digit first, XLEN/2 digit cycles per op).
// Optional compare flags (lt/ltu) are built only when SERIAL_ALU_CMP_EN is defined.
module serial_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       wr_req,
  input  logic       use_imm,
  input  logic [1:0] rs1_digit,
  input  logic [1:0] rs2_digit,
  input  logic [1:0] imm_digit,
  output logic [1:0] rd_digit,
  output logic       shift,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       zero,
  output logic       lt,
  output logic       ltu
);

  localparam int NDIGITS = XLEN / 2;
  localparam int CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIGITS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      op_r;
  logic            wr_req_r;
  logic            use_imm_r;
  logic            carry_r;
  logic            zero_acc_r;
  logic            zero_r;
  logic [1:0]      b_s;
  logic [1:0]      bp_s;
  logic [2:0]      sum_s;
  logic [1:0]      res_s;
  logic            is_sub_s;
  logic            is_arith_s;
  logic            last_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start outside IDLE is simply dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Digit datapath: zero-latency from the current digits and the carry register
  always_comb begin
    is_sub_s   = (op_r == OP_SUB);
    is_arith_s = (op_r == OP_ADD) || (op_r == OP_SUB);
    last_s     = (state_r == ST_RUN) && (cnt_r == LAST_DIGIT);
    if (use_imm_r) begin
      b_s = imm_digit;
    end else begin
      b_s = rs2_digit;
    end
    if (is_sub_s) begin
      bp_s = ~b_s;
    end else begin
      bp_s = b_s;
    end
    sum_s = {1'b0, rs1_digit} + {1'b0, bp_s} + {2'b00, carry_r};
    case (op_r)
      OP_ADD:  res_s = sum_s[1:0];
      OP_SUB:  res_s = sum_s[1:0];
      OP_AND:  res_s = rs1_digit & b_s;
      OP_OR:   res_s = rs1_digit | b_s;
      OP_XOR:  res_s = rs1_digit ^ b_s;
      default: res_s = rs1_digit;
    endcase
    if (state_r == ST_RUN) begin
      rd_digit = res_s;
    end else begin
      rd_digit = 2'b00;
    end
  end

  // Operation context, carry chain, digit counter and zero accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r       <= 3'd0;
      wr_req_r   <= 1'b0;
      use_imm_r  <= 1'b0;
      carry_r    <= 1'b0;
      cnt_r      <= '0;
      zero_acc_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r       <= op;
            wr_req_r   <= wr_req;
            use_imm_r  <= use_imm;
            carry_r    <= (op == OP_SUB);
            cnt_r      <= '0;
            zero_acc_r <= 1'b1;
            zero_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (is_arith_s) begin
            carry_r <= sum_s[2];
          end
          zero_acc_r <= zero_acc_r & (rd_digit == 2'b00);
          if (last_s) begin
            cnt_r  <= '0;
            zero_r <= zero_acc_r & (rd_digit == 2'b00);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ALU_CMP_EN
  logic lt_r;
  logic ltu_r;
  logic ovf_s;

  always_comb begin
    ovf_s = (rs1_digit[1] == bp_s[1]) && (sum_s[1] != rs1_digit[1]);
  end

  // Compare flags from the MSB digit: signed via sign^overflow, unsigned via borrow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lt_r  <= 1'b0;
      ltu_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      lt_r  <= 1'b0;
      ltu_r <= 1'b0;
    end else if (last_s) begin
      lt_r  <= is_sub_s & (sum_s[1] ^ ovf_s);
      ltu_r <= is_sub_s & ~sum_s[2];
    end else begin
      lt_r  <= lt_r;
      ltu_r <= ltu_r;
    end
  end

  assign lt  = lt_r;
  assign ltu = ltu_r;
`else
  assign lt  = 1'b0;
  assign ltu = 1'b0;
`endif

  assign shift = (state_r == ST_RUN);
  assign wr_en = (state_r == ST_RUN) & wr_req_r;
  assign busy  = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign done  = (state_r == ST_DONE);
  assign zero  = zero_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq against a whole-word arithmetic model.
// Follows the DUT build: compile both with SERIAL_ALU_CMP_EN to check the compare flags.
module tb_serial_alu_seq;

  localparam int XLEN    = 32;
  localparam int NDIGITS = XLEN / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic       wr_req;
  logic       use_imm;
  logic [1:0] rs1_digit;
  logic [1:0] rs2_digit;
  logic [1:0] imm_digit;
  logic [1:0] rd_digit;
  logic       shift;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       zero;
  logic       lt;
  logic       ltu;

  int checks   = 0;
  int failures = 0;

  serial_alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .wr_req    (wr_req),
    .use_imm   (use_imm),
    .rs1_digit (rs1_digit),
    .rs2_digit (rs2_digit),
    .imm_digit (imm_digit),
    .rd_digit  (rd_digit),
    .shift     (shift),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Whole-word reference: result and flags straight from the operation definitions
  task automatic model(input logic [2:0] op_i, input logic [31:0] a, input logic [31:0] b2,
                       output logic [31:0] res, output logic z, output logic slt, output logic sltu);
    case (op_i)
      3'd0:    res = a + b2;
      3'd1:    res = a - b2;
      3'd2:    res = a & b2;
      3'd3:    res = a | b2;
      3'd4:    res = a ^ b2;
      default: res = a;
    endcase
    z = (res == 32'd0);
`ifdef SERIAL_ALU_CMP_EN
    slt  = (op_i == 3'd1) && ($signed(a) < $signed(b2));
    sltu = (op_i == 3'd1) && (a < b2);
`else
    slt  = 1'b0;
    sltu = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic ui, input logic wr, input logic poke);
    logic [31:0] exp_res, got;
    logic exp_z, exp_lt, exp_ltu;
    int nshift, nwr, nbusy, ndone;
    model(op_i, a, ui ? imm : b, exp_res, exp_z, exp_lt, exp_ltu);
    got = 32'd0; nshift = 0; nwr = 0; nbusy = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1; op = op_i; use_imm = ui; wr_req = wr;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); use_imm = 1'($urandom); wr_req = 1'($urandom);
    for (int k = 0; k < NDIGITS; k++) begin
      rs1_digit = a[2*k +: 2];
      rs2_digit = b[2*k +: 2];
      imm_digit = imm[2*k +: 2];
      start     = poke && (k == 4);
      @(negedge clk);
      if (k == 0) begin
        check_eq("flags_cleared_at_run", {29'd0, zero, lt, ltu}, 32'd0);
      end
      nshift += int'(shift);
      nwr    += int'(wr_en);
      nbusy  += int'(busy);
      ndone  += int'(done);
      got[2*k +: 2] = rd_digit;
      @(posedge clk); #1;
    end
    start = poke;
    rs1_digit = 2'($urandom); rs2_digit = 2'($urandom); imm_digit = 2'($urandom);
    check_eq("shift_count", nshift, NDIGITS);
    check_eq("wr_en_count", nwr, wr ? NDIGITS : 0);
    check_eq("busy_in_run", nbusy, NDIGITS);
    check_eq("no_early_done", ndone, 0);
    check_eq("result", got, exp_res);
    @(negedge clk);
    check_eq("done_cycle_ctl", {27'd0, done, busy, shift, wr_en, 1'b0}, {27'd0, 4'b1100, 1'b0});
    check_eq("done_rd_digit", {30'd0, rd_digit}, 32'd0);
    check_eq("flags_at_done", {29'd0, zero, lt, ltu}, {29'd0, exp_z, exp_lt, exp_ltu});
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("idle_after_done", {30'd0, busy, done}, 32'd0);
    check_eq("flags_held", {29'd0, zero, lt, ltu}, {29'd0, exp_z, exp_lt, exp_ltu});
  endtask

  task automatic run_abort;
    int nshift;
    nshift = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; use_imm = 1'b0; wr_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      rs1_digit = 2'($urandom); rs2_digit = 2'($urandom); imm_digit = 2'($urandom);
      if (k == 8) begin
        rst_n = 1'b0;
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    check_eq("abort_outputs", {24'd0, rd_digit, shift, wr_en, busy, done, zero, lt, ltu}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nshift += int'(shift) + int'(wr_en) + int'(busy);
    end
    check_eq("abort_no_more_strobes", nshift, 0);
  endtask

  initial begin
    logic [2:0] r_op;
    logic [31:0] r_a, r_b, r_imm;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; wr_req = 1'b0; use_imm = 1'b0;
    rs1_digit = 2'd0; rs2_digit = 2'd0; imm_digit = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_outputs", {24'd0, rd_digit, shift, wr_en, busy, done, zero, lt, ltu}, 32'd0);

    run_op(3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(3'd1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd1, 1'b1, 1'b1, 1'b0);
    run_op(3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(3'd2, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op(3'd6, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(3'd3, 32'h0F0F_0000, 32'h00F0_00F0, 32'd7, 1'b1, 1'b1, 1'b1);
    run_op(3'd1, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom);
      r_a = $urandom; r_b = $urandom; r_imm = $urandom;
      if ($urandom_range(0, 3) == 0) r_b = r_a;
      if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
      run_op(r_op, r_a, r_b, r_imm, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    run_abort();
    run_op(3'd0, 32'd100, 32'd23, 32'd0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
